five_stage_memory_responder: RTL and testbench

Memory-side responder for the five-stage core's fetch and data-memory interfaces. It is the endpoint that the hazard logic waits on through `ready` and `valid`. It accepts one read or write request per cycle into a word-addressed on-chip array and returns read data after a fixed `LATENCY`. An optional post-accept busy window models slow memory so that issue and receive hazards can be exercised. One instance serves the I-side and one the D-side.

---
 rtl/five_stage_memory_responder.sv | 142 ++++++++++++++
 tb/tb_five_stage_memory_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/five_stage_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : five_stage_memory_responder
// Description : Word-addressed on-chip memory endpoint with fixed read latency
//               and an optional post-accept busy window (I-side or D-side).
// Revision    : 1.0 - initial release
// ============================================================================
module five_stage_memory_responder #(
  parameter int    CORE            = 0,
  parameter int    DATA_WIDTH      = 32,
  parameter int    NUM_BYTES       = DATA_WIDTH / 8,
  parameter int    ADDRESS_BITS    = 20,
  parameter int    INDEX_BITS      = 10,
  parameter int    LATENCY         = 2,
  parameter int    BUSY_CYCLES     = 0,
  parameter string INIT_FILE       = "",
  parameter int    SCAN_CYCLES_MIN = 0,
  parameter int    SCAN_CYCLES_MAX = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    read,
  input  logic                    write,
  input  logic [NUM_BYTES-1:0]    byte_en,
  input  logic [ADDRESS_BITS-1:0] address,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    ready,
  output logic                    valid,
  output logic [ADDRESS_BITS-1:0] out_address,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    conflict,
  input  logic                    scan
);

  localparam int          c_LOG2_NUM_BYTES = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 0;
  localparam int          c_DEPTH          = 2 ** INDEX_BITS;
  localparam bit          c_HAS_BUSY       = (BUSY_CYCLES > 0);
  localparam logic [3:0]  c_BUSY_LOAD      = 4'((BUSY_CYCLES > 0) ? BUSY_CYCLES - 1 : 0);

  typedef enum logic [0:0] {
    S_READY = 1'b0,
    S_BUSY  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [3:0]              r_busy_cnt;
  logic [3:0]              w_busy_cnt_next;

  logic [DATA_WIDTH-1:0]   r_mem [c_DEPTH];

  logic [LATENCY-1:0]      r_pipe_valid;
  logic [ADDRESS_BITS-1:0] r_pipe_addr [LATENCY];
  logic [DATA_WIDTH-1:0]   r_pipe_data [LATENCY];
  logic                    r_conflict;

  logic                    w_accept;
  logic                    w_read_accept;
  logic                    w_write_accept;
  logic [INDEX_BITS-1:0]   w_index;

  assign ready          = (r_state == S_READY);
  assign w_accept       = ready & (read | write);
  // A simultaneous read+write behaves as a write and returns nothing.
  assign w_read_accept  = w_accept & read & ~write;
  assign w_write_accept = w_accept & write;
  assign w_index        = address[c_LOG2_NUM_BYTES +: INDEX_BITS];

  // Trace and preload hooks are not modelled in hardware.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{scan, address, (CORE != 0), (INIT_FILE != ""),
                          (SCAN_CYCLES_MIN > SCAN_CYCLES_MAX)};

  always_ff @(posedge clock) begin
    if (w_write_accept) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (byte_en[b]) begin
          r_mem[w_index][b*8 +: 8] <= in_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pipe_valid <= '0;
      r_conflict   <= 1'b0;
      for (int s = 0; s < LATENCY; s++) begin
        r_pipe_addr[s] <= '0;
        r_pipe_data[s] <= '0;
      end
    end else begin
      r_conflict      <= w_accept & read & write;
      r_pipe_valid[0] <= w_read_accept;
      r_pipe_addr[0]  <= w_read_accept ? address : '0;
      r_pipe_data[0]  <= w_read_accept ? r_mem[w_index] : '0;
      for (int s = 1; s < LATENCY; s++) begin
        r_pipe_valid[s] <= r_pipe_valid[s-1];
        r_pipe_addr[s]  <= r_pipe_addr[s-1];
        r_pipe_data[s]  <= r_pipe_data[s-1];
      end
    end
  end

  assign valid       = r_pipe_valid[LATENCY-1];
  assign out_address = r_pipe_addr[LATENCY-1];
  assign out_data    = r_pipe_data[LATENCY-1];
  assign conflict    = r_conflict;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_READY;
      r_busy_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_busy_cnt <= w_busy_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_busy_cnt_next = r_busy_cnt;
    case (r_state)
      S_READY: begin
        if (w_accept && c_HAS_BUSY) begin
          w_state_next    = S_BUSY;
          w_busy_cnt_next = c_BUSY_LOAD;
        end
      end
      S_BUSY: begin
        if (r_busy_cnt == 4'd0) begin
          w_state_next = S_READY;
        end else begin
          w_busy_cnt_next = r_busy_cnt - 4'd1;
        end
      end
      default: w_state_next = S_READY;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_five_stage_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_five_stage_memory_responder
// Description : Directed bench for the memory responder (LATENCY=2 with and
//               without a 3-cycle busy window).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_five_stage_memory_responder;

  localparam int DW = 32;
  localparam int AW = 20;

  logic          clock;
  logic          scan;
  int            n_tests;
  int            n_fail;

  logic          reset, read, write, ready, valid, conflict;
  logic [3:0]    byte_en;
  logic [AW-1:0] address, out_address;
  logic [DW-1:0] in_data, out_data;

  logic          reset_b, read_b, write_b, ready_b, valid_b, conflict_b;
  logic [3:0]    byte_en_b;
  logic [AW-1:0] address_b, out_address_b;
  logic [DW-1:0] in_data_b, out_data_b;

  logic [7:0]    exp_ready_pat;
  logic [7:0]    exp_valid_pat;

  five_stage_memory_responder #(.LATENCY(2), .BUSY_CYCLES(0)) dut_a (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .byte_en(byte_en), .address(address), .in_data(in_data),
    .ready(ready), .valid(valid), .out_address(out_address),
    .out_data(out_data), .conflict(conflict), .scan(scan)
  );

  five_stage_memory_responder #(.LATENCY(2), .BUSY_CYCLES(3)) dut_b (
    .clock(clock), .reset(reset_b), .read(read_b), .write(write_b),
    .byte_en(byte_en_b), .address(address_b), .in_data(in_data_b),
    .ready(ready_b), .valid(valid_b), .out_address(out_address_b),
    .out_data(out_data_b), .conflict(conflict_b), .scan(scan)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] be,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    read = r; write = w; byte_en = be; address = a; in_data = d;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    scan    = 1'b0;
    reset   = 1'b0;
    reset_b = 1'b0;
    drive(1'b0, 1'b0, 4'h0, '0, '0);
    read_b = 1'b0; write_b = 1'b0; byte_en_b = 4'h0; address_b = '0; in_data_b = '0;

    // Reset state
    tick;
    check("rst_ready",    ready,       1);
    check("rst_valid",    valid,       0);
    check("rst_out_addr", out_address, 0);
    check("rst_out_data", out_data,    0);
    check("rst_conflict", conflict,    0);
    check("rst_ready_b",  ready_b,     1);
    tick;
    reset   = 1'b1;
    reset_b = 1'b1;

    // Write then read, read issued on the very next edge
    drive(1'b0, 1'b1, 4'hF, 20'h40, 32'hDEADBEEF);
    tick;
    check("wr_conflict", conflict, 0);
    check("wr_valid",    valid,    0);
    drive(1'b1, 1'b0, 4'h0, 20'h40, 32'h0);
    tick;
    check("rd_lat1_valid", valid, 0);
    drive(1'b0, 1'b0, 4'h0, 20'h0, 32'h0);
    tick;
    check("rd_lat2_valid", valid,       1);
    check("rd_data",       out_data,    32'hDEADBEEF);
    check("rd_addr",       out_address, 20'h40);
    tick;
    check("rd_pulse_end",  valid,       0);

    // Partial write, read back through an aliased address
    drive(1'b0, 1'b1, 4'b0001, 20'h40, 32'h000000AA);
    tick;
    drive(1'b1, 1'b0, 4'h0, 20'h1042, 32'h0);
    tick;
    drive(1'b0, 1'b0, 4'h0, 20'h0, 32'h0);
    tick;
    check("part_valid", valid,       1);
    check("part_data",  out_data,    32'hDEADBEAA);
    check("part_addr",  out_address, 20'h1042);

    // Back-to-back writes then back-to-back reads
    drive(1'b0, 1'b1, 4'hF, 20'h0, 32'h11111111);
    tick;
    check("b2b_wr_ready0", ready, 1);
    drive(1'b0, 1'b1, 4'hF, 20'h4, 32'h22222222);
    tick;
    check("b2b_wr_ready1", ready, 1);
    drive(1'b0, 1'b1, 4'hF, 20'h8, 32'h33333333);
    tick;
    drive(1'b1, 1'b0, 4'h0, 20'h0, 32'h0);
    tick;
    check("b2b_rd_ready0", ready, 1);
    check("b2b_rd_v0",     valid, 0);
    drive(1'b1, 1'b0, 4'h0, 20'h4, 32'h0);
    tick;
    check("b2b_rd_ready1", ready,       1);
    check("b2b_rd_v1",     valid,       1);
    check("b2b_rd_a1",     out_address, 20'h0);
    check("b2b_rd_d1",     out_data,    32'h11111111);
    drive(1'b1, 1'b0, 4'h0, 20'h8, 32'h0);
    tick;
    check("b2b_rd_v2", valid,       1);
    check("b2b_rd_a2", out_address, 20'h4);
    check("b2b_rd_d2", out_data,    32'h22222222);
    drive(1'b0, 1'b0, 4'h0, 20'h0, 32'h0);
    tick;
    check("b2b_rd_v3", valid,       1);
    check("b2b_rd_a3", out_address, 20'h8);
    check("b2b_rd_d3", out_data,    32'h33333333);
    tick;
    check("b2b_rd_v4", valid, 0);

    // Read and write together: write wins, no response
    drive(1'b1, 1'b1, 4'hF, 20'h80, 32'h12345678);
    tick;
    check("cf_pulse", conflict, 1);
    check("cf_v0",    valid,    0);
    drive(1'b0, 1'b0, 4'h0, 20'h0, 32'h0);
    tick;
    check("cf_pulse_end", conflict, 0);
    check("cf_v1",        valid,    0);
    tick;
    check("cf_v2", valid, 0);
    drive(1'b1, 1'b0, 4'h0, 20'h80, 32'h0);
    tick;
    drive(1'b0, 1'b0, 4'h0, 20'h0, 32'h0);
    tick;
    check("cf_rd_valid", valid,    1);
    check("cf_rd_data",  out_data, 32'h12345678);

    // Reset with two reads in flight
    drive(1'b1, 1'b0, 4'h0, 20'h0, 32'h0);
    tick;
    drive(1'b1, 1'b0, 4'h0, 20'h4, 32'h0);
    tick;
    check("inflight_valid", valid, 1);
    drive(1'b0, 1'b0, 4'h0, 20'h0, 32'h0);
    #2 reset = 1'b0;
    #1;
    check("async_rst_valid", valid,    0);
    check("async_rst_ready", ready,    1);
    check("async_rst_data",  out_data, 0);
    tick;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      check($sformatf("post_rst_v%0d", k), valid, 0);
    end
    drive(1'b1, 1'b0, 4'h0, 20'h8, 32'h0);
    tick;
    drive(1'b0, 1'b0, 4'h0, 20'h0, 32'h0);
    tick;
    check("post_rst_rd_valid", valid,    1);
    check("post_rst_rd_data",  out_data, 32'h33333333);

    // Busy window of 3 with a continuously held read
    exp_ready_pat = 8'b1000_1000;
    exp_valid_pat = 8'b0010_0010;
    read_b    = 1'b1;
    address_b = 20'h0;
    for (int k = 0; k < 8; k++) begin
      tick;
      check($sformatf("busy_ready_t%0d", k + 1), ready_b, exp_ready_pat[k]);
      check($sformatf("busy_valid_t%0d", k + 1), valid_b, exp_valid_pat[k]);
    end
    tick;
    check("busy_reaccept", ready_b, 0);
    read_b = 1'b0;
    #2 reset_b = 1'b0;
    #1;
    check("busy_async_rst_ready", ready_b, 1);
    check("busy_async_rst_valid", valid_b, 0);
    tick;
    reset_b = 1'b1;
    tick;
    check("busy_post_rst_ready", ready_b, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
